// File: rtl/edge_pkg.sv
// Shared definitions for the multi-channel edge detector.
//
// Contents:
//   edge_mode_t     - per-channel 2-bit edge selection
//   MODE_W          - width of one channel's mode field
//   MODE_RISE_BIT   - bit within a mode field that enables rising edges
//   MODE_FALL_BIT   - bit within a mode field that enables falling edges
package edge_pkg;

    typedef enum logic [1:0] {
        EDGE_OFF  = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_t;

    localparam int MODE_W        = 2;
    localparam int MODE_RISE_BIT = 0;
    localparam int MODE_FALL_BIT = 1;

endpackage

// File: rtl/edge_channel.sv
// One channel of the edge detector: input sample register, debounce filter,
// debounced level, registered edge pulse and sticky pending flag.
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   sig_in     in   already-synchronised input level
//   mode       in   edge selection (off / rise / fall / both)
//   clr        in   write-1 pulse clearing pending
//   edge_pulse out  one-cycle pulse on a qualified edge
//   level      out  debounced level
//   pending    out  sticky qualified-edge flag
module edge_channel
    import edge_pkg::*;
#(
    parameter int DB_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sig_in,
    input  edge_mode_t mode,
    input  logic       clr,
    output logic       edge_pulse,
    output logic       level,
    output logic       pending
);

    localparam int                CNT_W    = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             s;
    logic [CNT_W-1:0] cnt;
    logic             change;
    logic             pulse_next;

    // A level change is accepted when the sample has disagreed with the
    // current level for DB_CYCLES consecutive edges. The new level is the
    // sample itself, so s tells rise from fall.
    always_comb begin
        change     = 1'b0;
        pulse_next = 1'b0;
        change     = (s != level) && (cnt == CNT_LAST);
        pulse_next = (change &  s & mode[MODE_RISE_BIT]) |
                     (change & ~s & mode[MODE_FALL_BIT]);
    end

    // Set has priority over clear on pending so an edge landing in the same
    // cycle as a clear write is never lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            s          <= 1'b0;
            cnt        <= '0;
            level      <= 1'b0;
            edge_pulse <= 1'b0;
            pending    <= 1'b0;
        end else begin
            s <= sig_in;
            if (s == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= s;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            edge_pulse <= pulse_next;
            pending    <= (pending & ~clr) | pulse_next;
        end
    end

endmodule

// File: rtl/edge_detector_multi.sv
// N-channel debounced edge detector with per-channel run-time edge
// selection, sticky pending flags and a combined interrupt line.
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   sig_in     in   [NUM_CH]    synchronised input levels
//   mode       in   [2*NUM_CH]  channel i mode in bits [2i+1:2i]
//                               (00 off, 01 rise, 10 fall, 11 both)
//   clr        in   [NUM_CH]    write-1 pulses clearing pending bits
//   irq_en     in   [NUM_CH]    per-channel interrupt enable
//   edge_pulse out  [NUM_CH]    one-cycle pulse per qualified edge
//   level      out  [NUM_CH]    debounced levels
//   pending    out  [NUM_CH]    sticky qualified-edge flags
//   irq        out  1           OR of (pending & irq_en)
module edge_detector_multi
    import edge_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int DB_CYCLES = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          sig_in,
    input  logic [MODE_W*NUM_CH-1:0]   mode,
    input  logic [NUM_CH-1:0]          clr,
    input  logic [NUM_CH-1:0]          irq_en,
    output logic [NUM_CH-1:0]          edge_pulse,
    output logic [NUM_CH-1:0]          level,
    output logic [NUM_CH-1:0]          pending,
    output logic                       irq
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        edge_channel #(
            .DB_CYCLES (DB_CYCLES)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .sig_in     (sig_in[i]),
            .mode       (edge_mode_t'(mode[MODE_W*i +: MODE_W])),
            .clr        (clr[i]),
            .edge_pulse (edge_pulse[i]),
            .level      (level[i]),
            .pending    (pending[i])
        );
    end

    // Enable only masks the interrupt; pending keeps latching regardless.
    assign irq = |(pending & irq_en);

endmodule
